// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Purpose:
//   A NUM_REGS x DATA_WIDTH register file with two combinational read ports
//   and one synchronous write port. The storage has no reset of its own.
//   Instead, a two-state controller sweeps zeros through every register after
//   reset, or after a clear_all request, before it reports ready and accepts
//   writes. Reads return zero while the file is not ready. When a read address
//   matches a write that is accepted in the same cycle, the read returns the
//   incoming write data.
//
// Ports:
//   clk            in   single clock, all state changes on the rising edge
//   rst            in   asynchronous active-high reset
//   write_enable   in   write request this cycle
//   write_address  in   [ADDR_WIDTH-1:0] register to write
//   write_data     in   [DATA_WIDTH-1:0] value to write
//   read_reg_0     in   [ADDR_WIDTH-1:0] read port 0 address
//   read_reg_1     in   [ADDR_WIDTH-1:0] read port 1 address
//   clear_all      in   synchronous request to re-zero every register
//   read_data_0    out  [DATA_WIDTH-1:0] port 0 read value (combinational)
//   read_data_1    out  [DATA_WIDTH-1:0] port 1 read value (combinational)
//   ready          out  registered; 1 = file initialised, writes accepted
//   write_dropped  out  registered one-cycle pulse; a write was refused
// -----------------------------------------------------------------------------
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_reg_0,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic                  clear_all,
    output logic [DATA_WIDTH-1:0] read_data_0,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic                  ready,
    output logic                  write_dropped
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clear_count;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    // A write lands only in READY and only when no clear is requested.
    // Any other write request is refused and reported one cycle later.
    logic write_accept;
    logic write_refuse;

    assign write_accept = (state == ST_READY) && write_enable && !clear_all;
    assign write_refuse = write_enable && ((state == ST_INIT) || clear_all);

    // -------------------------------------------------------------------------
    // Controller: sweep state, sweep pointer and the registered status outputs.
    // -------------------------------------------------------------------------
    // NOTE: all registered state uses non-blocking assignments, so every flop
    // samples values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_INIT;
            clear_count   <= '0;
            ready         <= 1'b0;
            write_dropped <= 1'b0;
        end else begin
            write_dropped <= write_refuse;
            case (state)
                ST_INIT: begin
                    // clear_all is ignored here; the sweep simply runs on.
                    // After the last register the pointer wraps back to 0.
                    clear_count <= clear_count + 1'b1;
                    if (clear_count == LAST_ADDR) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (clear_all) begin
                        state       <= ST_INIT;
                        clear_count <= '0;
                        ready       <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_INIT;
                    clear_count <= '0;
                    ready       <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Storage.
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset branch. Resetting it would force every bit
    // to become a resettable flop and rule out a RAM implementation. The INIT
    // sweep gives the defined contents, and reads are held at zero until the
    // sweep has finished.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            regs[clear_count] <= '0;
        end else if (write_accept) begin
            regs[write_address] <= write_data;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports: zero until ready, then array contents with write bypass.
    // -------------------------------------------------------------------------
    // NOTE: each output gets a default at the top of the block. That way no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        read_data_0 = '0;
        if (ready) begin
            if (write_accept && (read_reg_0 == write_address)) begin
                read_data_0 = write_data;
            end else begin
                read_data_0 = regs[read_reg_0];
            end
        end
    end

    always_comb begin
        read_data_1 = '0;
        if (ready) begin
            if (write_accept && (read_reg_1 == write_address)) begin
                read_data_1 = write_data;
            end else begin
                read_data_1 = regs[read_reg_1];
            end
        end
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each register and of all data ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: register address width; NUM_REGS = 2**ADDR_WIDTH (32).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port write_enable  input  1: write request this cycle.
REQ-006 SHALL have port write_address  input  ADDR_WIDTH: register to write.
REQ-007 SHALL have port write_data  input  DATA_WIDTH: value to write.
REQ-008 SHALL have port read_reg_0  input  ADDR_WIDTH: read port 0 address.
REQ-009 SHALL have port read_reg_1  input  ADDR_WIDTH: read port 1 address.
REQ-010 SHALL have port clear_all  input  1: synchronous request to re-zero all registers.
REQ-011 SHALL have port read_data_0  output  DATA_WIDTH: port 0 read value, combinational.
REQ-012 SHALL have port read_data_1  output  DATA_WIDTH: port 1 read value, combinational.
REQ-013 SHALL have port ready  output  1: registered; 1 = file initialised, writes accepted.
REQ-014 SHALL have port write_dropped  output  1: registered one-cycle pulse; a write was refused.

Function
REQ-015 SHALL hold NUM_REGS x DATA_WIDTH storage; storage itself is not asynchronously reset.
REQ-016 SHALL implement a 2-state FSM: INIT (sweep clear) and READY.
REQ-017 SHALL, in INIT, on each rising edge write 0 to register clear_count and increment clear_count (ADDR_WIDTH bits).
REQ-018 SHALL transition INIT->READY on the edge that clears register NUM_REGS-1, setting ready=1 on that same edge; clear_count wraps to 0.
REQ-019 SHALL, in READY with write_enable=1 and clear_all=0, write write_data to register write_address on the rising edge; all 32 addresses writable, no hardwired zero.
REQ-020 SHALL, in READY with clear_all=1, go to INIT on the next edge with clear_count=0, ready=0; a simultaneous write is dropped.
REQ-021 SHALL refuse any write with write_enable=1 while in INIT or coincident with clear_all=1, and pulse write_dropped=1 for exactly the following cycle; otherwise write_dropped=0.
REQ-022 SHALL drive read_data_N = 0 whenever ready=0, regardless of address.
REQ-023 SHALL, when ready=1, drive read_data_N = register[read_reg_N], combinationally (zero-cycle read latency).
REQ-024 SHALL bypass: when ready=1, write_enable=1, clear_all=0, and read_reg_N == write_address, read_data_N = write_data in the same cycle.
REQ-025 SHALL serve both read ports independently; identical addresses on both ports return identical data.
REQ-026 SHALL ignore clear_all asserted during INIT (sweep continues, no restart).

Reset
REQ-027 SHALL, while rst=1, immediately force state=INIT, clear_count=0, ready=0, write_dropped=0, and hence read_data_0=read_data_1=0.
REQ-028 SHALL, after rst deasserts, complete the sweep in exactly 32 rising edges; ready=1 after the 32nd edge.
REQ-029 SHALL, on rst asserted mid-sweep or mid-operation, abandon state and restart the full 32-edge sweep after deassertion; prior register contents are not preserved.

Verification
REQ-030 SHALL cover: reset release, count edges -> ready=0 for edges 1-31, ready=1 after edge 32, reads of all 32 regs return 0.
REQ-031 SHALL cover: ready=1, write reg 7 = 0xDEADBEEF, next cycle read_reg_0=7, read_reg_1=7 -> both 0xDEADBEEF; reg 31 write 0x1 -> reads 0x1.
REQ-032 SHALL cover: write reg 3 = 0x12345678 with read_reg_1=3 same cycle -> read_data_1=0x12345678 before the edge (bypass); read_reg_0=4 unaffected.
REQ-033 SHALL cover: write_enable=1 during INIT (edge 5 after reset) -> write_dropped=1 next cycle only, target reg reads 0 after ready.
REQ-034 SHALL cover: ready=1, regs loaded nonzero, clear_all=1 with write reg 2=0xAA -> write_dropped pulse, ready=0 next cycle, 32 edges later ready=1, all regs 0.
REQ-035 SHALL cover: rst pulsed at sweep edge 10 -> ready stays 0 for a full 32 edges after deassertion, then all reads 0.
